// File: rtl/bsg_noc_crossbar_pkg.sv
// Shared constants and helpers for the crossbar memory endpoint.
// The response entry struct is declared in the top module because its widths depend on module parameters.
package bsg_noc_crossbar_pkg;

    // A write ack carries all-zero data; replicate this bit to the data width.
    localparam logic write_ack_data = 1'b0;

    // Wrap explicitly so that depths that are not a power of two still cycle correctly.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned els);
        return (ptr == els - 1) ? '0 : ptr + 1;
    endfunction

endpackage

// File: rtl/bsg_noc_crossbar_mem_endpoint_resp_fifo.sv
// Small 1r1w FIFO holding completed responses; owns all pointer and count state.
module bsg_noc_crossbar_mem_endpoint_resp_fifo
    import bsg_noc_crossbar_pkg::*;
#(
    parameter int els_p   = 2,
    parameter int width_p = 33,
    localparam int count_width_lp = $clog2(els_p + 1),
    localparam int ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1
)
(
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      enq_i,
    input  logic [width_p-1:0]        data_i,
    input  logic                      deq_i,
    output logic [width_p-1:0]        data_o,
    output logic [count_width_lp-1:0] count_o,
    output logic                      v_o
);

    logic [ptr_width_lp-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ptr_width_lp-1:0]   rd_ptr_q, rd_ptr_d;
    logic [count_width_lp-1:0] count_q, count_d;
    logic [width_p-1:0]        mem_q [els_p];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq_i) wr_ptr_d = ptr_width_lp'(wrap_inc(32'(wr_ptr_q), els_p));
        if (deq_i) rd_ptr_d = ptr_width_lp'(wrap_inc(32'(rd_ptr_q), els_p));
        if (enq_i && !deq_i)
            count_d = count_q + count_width_lp'(1);
        else if (!enq_i && deq_i)
            count_d = count_q - count_width_lp'(1);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates visibility of every entry.
    always_ff @(posedge clk_i) begin
        if (enq_i) mem_q[wr_ptr_q] <= data_i;
    end

    // The upstream credit check must make a net enqueue into a full buffer impossible.
    always_ff @(posedge clk_i) begin
        if (!reset_i) assert (!(enq_i && !deq_i && (count_q == count_width_lp'(els_p))));
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign v_o     = (count_q != '0);

endmodule

// File: rtl/bsg_noc_crossbar_mem_endpoint.sv
// Responder endpoint: issues crossbar requests to a 1-cycle synchronous memory and returns tagged responses.
// req_yumi_o is combinational from req_v_i and resp_ready_i.
module bsg_noc_crossbar_mem_endpoint
    import bsg_noc_crossbar_pkg::*;
#(
    parameter int addr_width_p = 2,
    parameter int data_width_p = 32,
    parameter int id_width_p   = 1,
    parameter int resp_els_p   = 2
)
(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [addr_width_p-1:0] req_addr_i,
    input  logic [data_width_p-1:0] req_data_i,
    input  logic                    req_w_i,
    input  logic [id_width_p-1:0]   req_src_id_i,
    input  logic                    req_v_i,
    output logic                    req_yumi_o,
    output logic [addr_width_p-1:0] mem_addr_o,
    output logic [data_width_p-1:0] mem_data_o,
    output logic                    mem_w_o,
    output logic                    mem_v_o,
    input  logic [data_width_p-1:0] mem_data_i,
    output logic [id_width_p-1:0]   resp_dest_id_o,
    output logic [data_width_p-1:0] resp_data_o,
    output logic                    resp_v_o,
    input  logic                    resp_ready_i
);

    typedef struct packed {
        logic [id_width_p-1:0]   dest_id;
        logic [data_width_p-1:0] data;
    } resp_entry_t;

    localparam int count_width_lp = $clog2(resp_els_p + 1);

    logic                      inflight_v_q;
    logic                      inflight_w_q;
    logic [id_width_p-1:0]     inflight_id_q;
    logic                      deq;
    logic                      slot_ok;
    logic [count_width_lp-1:0] count;
    resp_entry_t               enq_entry;
    resp_entry_t               head_entry;

    // The in-flight access already owns a slot, so it counts against the credit alongside buffered entries.
    assign deq        = resp_v_o & resp_ready_i;
    assign slot_ok    = (32'(count) + 32'(inflight_v_q) - 32'(deq)) < 32'(resp_els_p);
    assign req_yumi_o = req_v_i & slot_ok & ~reset_i;

    assign mem_v_o    = req_yumi_o;
    assign mem_addr_o = req_addr_i;
    assign mem_data_o = req_data_i;
    assign mem_w_o    = req_w_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            inflight_v_q  <= 1'b0;
            inflight_w_q  <= 1'b0;
            inflight_id_q <= '0;
        end else begin
            inflight_v_q  <= req_yumi_o;
            inflight_w_q  <= req_w_i;
            inflight_id_q <= req_src_id_i;
        end
    end

    assign enq_entry.dest_id = inflight_id_q;
    assign enq_entry.data    = inflight_w_q ? {data_width_p{write_ack_data}} : mem_data_i;

    bsg_noc_crossbar_mem_endpoint_resp_fifo #(
        .els_p   (resp_els_p),
        .width_p ($bits(resp_entry_t))
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .enq_i   (inflight_v_q),
        .data_i  (enq_entry),
        .deq_i   (deq),
        .data_o  (head_entry),
        .count_o (count),
        .v_o     (resp_v_o)
    );

    assign resp_dest_id_o = head_entry.dest_id;
    assign resp_data_o    = head_entry.data;

endmodule

// File: tb/tb_bsg_noc_crossbar_mem_endpoint.sv
// Self-checking bench for bsg_noc_crossbar_mem_endpoint: directed scenarios plus a random phase,
// checked against a transaction-level model of outstanding requests.
module tb_bsg_noc_crossbar_mem_endpoint;

    localparam int ELS = 2;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [1:0]  req_addr_i;
    logic [31:0] req_data_i;
    logic        req_w_i;
    logic [0:0]  req_src_id_i;
    logic        req_v_i;
    logic        req_yumi_o;
    logic [1:0]  mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_w_o;
    logic        mem_v_o;
    logic [31:0] mem_data_i;
    logic [0:0]  resp_dest_id_o;
    logic [31:0] resp_data_o;
    logic        resp_v_o;
    logic        resp_ready_i;

    typedef struct {
        int          acc;
        logic [0:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] refMem[4];
    logic [31:0] tbMem[4];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          acceptTotal = 0;
    bit          lastYumi = 1'b0;

    bsg_noc_crossbar_mem_endpoint #(
        .addr_width_p(2), .data_width_p(32), .id_width_p(1), .resp_els_p(ELS)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_w_i(req_w_i),
        .req_src_id_i(req_src_id_i), .req_v_i(req_v_i), .req_yumi_o(req_yumi_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_w_o(mem_w_o), .mem_v_o(mem_v_o),
        .mem_data_i(mem_data_i),
        .resp_dest_id_o(resp_dest_id_o), .resp_data_o(resp_data_o), .resp_v_o(resp_v_o),
        .resp_ready_i(resp_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Environment memory: reloaded while reset is held, otherwise 1-cycle synchronous read/write.
    always @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 4; i++) tbMem[i] <= 32'h10 + 32'(i);
        end else if (mem_v_o) begin
            if (mem_w_o) tbMem[mem_addr_o] <= mem_data_o;
            else         mem_data_i <= tbMem[mem_addr_o];
        end
    end

    task automatic preloadRef();
        for (int i = 0; i < 4; i++) refMem[i] = 32'h10 + 32'(i);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock: check outputs at the negedge against the model, update the model, advance past posedge.
    task automatic stepCycle();
        bit expRespV;
        bit deqNow;
        bit expYumi;
        exp_t e;
        @(negedge clk_i);
        expRespV = (expQ.size() != 0) && (expQ[0].acc + 2 <= cyc);
        checkOutput("resp_v", 64'(resp_v_o), 64'(expRespV));
        if (expRespV) begin
            checkOutput("resp_data", 64'(resp_data_o), 64'(expQ[0].data));
            checkOutput("resp_id", 64'(resp_dest_id_o), 64'(expQ[0].id));
        end
        deqNow  = expRespV && resp_ready_i;
        expYumi = req_v_i && !reset_i && ((expQ.size() - int'(deqNow)) < ELS);
        checkOutput("req_yumi", 64'(req_yumi_o), 64'(expYumi));
        checkOutput("mem_v", 64'(mem_v_o), 64'(expYumi));
        if (expYumi) begin
            checkOutput("mem_addr", 64'(mem_addr_o), 64'(req_addr_i));
            checkOutput("mem_w", 64'(mem_w_o), 64'(req_w_i));
            if (req_w_i) checkOutput("mem_wdata", 64'(mem_data_o), 64'(req_data_i));
        end
        if (deqNow) void'(expQ.pop_front());
        if (expYumi) begin
            e.acc  = cyc;
            e.id   = req_src_id_i;
            e.data = req_w_i ? 32'h0 : refMem[req_addr_i];
            expQ.push_back(e);
            if (req_w_i) refMem[req_addr_i] = req_data_i;
            acceptTotal++;
        end
        lastYumi = expYumi;
        @(posedge clk_i);
        cyc++;
        #1;
    endtask

    // Hold a request valid until the model says it was consumed, with a bounded wait.
    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data,
                                 input logic w, input logic [0:0] id);
        int n = 0;
        req_v_i = 1'b1; req_addr_i = addr; req_data_i = data; req_w_i = w; req_src_id_i = id;
        do begin
            stepCycle();
            n++;
        end while (!lastYumi && n < 50);
        checks++;
        assert (lastYumi) else begin
            failures++;
            $error("FAIL accept_timeout observed=no_accept expected=accept addr=%0d", addr);
        end
        req_v_i = 1'b0;
    endtask

    task automatic idle(input int n);
        req_v_i = 1'b0;
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    initial begin
        int base;
        reset_i = 1'b1;
        req_v_i = 1'b1; req_addr_i = '0; req_data_i = '0; req_w_i = 1'b0; req_src_id_i = '0;
        resp_ready_i = 1'b1;
        preloadRef();
        #1;
        checkOutput("reset_yumi", 64'(req_yumi_o), 64'(0));
        checkOutput("reset_mem_v", 64'(mem_v_o), 64'(0));
        checkOutput("reset_resp_v", 64'(resp_v_o), 64'(0));
        req_v_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        idle(2);

        $display("[TB] streaming reads");
        for (int i = 0; i < 4; i++) applyStimulus(2'(i), 32'h0, 1'b0, 1'b0);
        idle(4);

        $display("[TB] write then read");
        applyStimulus(2'd1, 32'hDEADBEEF, 1'b1, 1'b0);
        applyStimulus(2'd1, 32'h0, 1'b0, 1'b0);
        idle(4);

        $display("[TB] back-pressure");
        resp_ready_i = 1'b0;
        base = acceptTotal;
        applyStimulus(2'd0, 32'h0, 1'b0, 1'b1);
        applyStimulus(2'd1, 32'h0, 1'b0, 1'b0);
        req_v_i = 1'b1; req_addr_i = 2'd2; req_w_i = 1'b0; req_src_id_i = 1'b1;
        for (int i = 0; i < 4; i++) stepCycle();
        checkOutput("bp_accepts", 64'(acceptTotal - base), 64'(ELS));
        resp_ready_i = 1'b1;
        applyStimulus(2'd2, 32'h0, 1'b0, 1'b1);
        applyStimulus(2'd3, 32'h0, 1'b0, 1'b0);
        applyStimulus(2'd1, 32'h0, 1'b0, 1'b1);
        idle(5);

        $display("[TB] id echo");
        for (int i = 0; i < 6; i++)
            applyStimulus(2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)), 1'(i % 2));
        idle(5);

        $display("[TB] full with simultaneous enq/deq");
        resp_ready_i = 1'b0;
        applyStimulus(2'd0, 32'h0, 1'b0, 1'b0);
        applyStimulus(2'd3, 32'h0, 1'b0, 1'b1);
        req_v_i = 1'b1; req_addr_i = 2'd2; req_w_i = 1'b0; req_src_id_i = 1'b0;
        stepCycle();
        stepCycle();
        resp_ready_i = 1'b1;
        base = acceptTotal;
        for (int i = 0; i < 8; i++) begin
            req_addr_i = 2'($urandom_range(0, 3));
            req_src_id_i = 1'(i % 2);
            stepCycle();
        end
        checkOutput("steady_accepts", 64'(acceptTotal - base), 64'(8));
        idle(5);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            req_v_i      = 1'($urandom_range(0, 3) != 0);
            req_addr_i   = 2'($urandom_range(0, 3));
            req_data_i   = $urandom;
            req_w_i      = 1'($urandom_range(0, 1));
            req_src_id_i = 1'($urandom_range(0, 1));
            resp_ready_i = 1'($urandom_range(0, 3) != 0);
            stepCycle();
        end
        resp_ready_i = 1'b1;
        idle(6);
        checkOutput("drained", 64'(expQ.size()), 64'(0));

        $display("[TB] reset mid-flight");
        resp_ready_i = 1'b0;
        applyStimulus(2'd2, 32'h0, 1'b0, 1'b0);
        applyStimulus(2'd3, 32'h0, 1'b0, 1'b1);
        resp_ready_i = 1'b1;
        req_v_i = 1'b1; req_addr_i = 2'd0; req_w_i = 1'b0;
        #2;
        reset_i = 1'b1;
        #1;
        checkOutput("async_rst_resp_v", 64'(resp_v_o), 64'(0));
        checkOutput("async_rst_yumi", 64'(req_yumi_o), 64'(0));
        expQ.delete();
        preloadRef();
        req_v_i = 1'b0;
        @(posedge clk_i);
        cyc++;
        #1;
        reset_i = 1'b0;
        idle(4);
        applyStimulus(2'd1, 32'h0, 1'b0, 1'b1);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
